uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit-side byte queue that feeds the simpleuart data register write port. Producers push ASCII bytes through a valid/ready port. The block buffers them in a FIFO and writes them one at a time into simpleuart (`reg_dat_we`/`reg_dat_di`), honouring `reg_dat_wait` back-pressure. It sits between design logic (status reporters, echo paths, command responders) and the UART transmitter.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..8.
- `clk` input 1: system clock; the same clock that drives simpleuart.
- `resetn` input 1: reset, synchronous, active-low.
- `in_valid` input 1: producer has a byte on `in_data`.
- `in_data` input 8: byte to queue.
- `in_ready` output 1: queue can accept a byte; a push occurs on any cycle with `in_valid && in_ready`.
- `flush` input 1: synchronous clear of the queue and any transmission not yet accepted.
- `reg_dat_we` output 1: write strobe to simpleuart.
- `reg_dat_di` output 32: `{24'h0, byte}` presented to simpleuart.
- `reg_dat_wait` input 1: simpleuart busy; a write is accepted on a cycle with `reg_dat_we && !reg_dat_wait`.
- `level` output DEPTH_LOG2+1: number of bytes currently stored.
- `overflow` output 1: sticky; set when `in_valid` is seen while full; cleared only by reset or `flush`.

## Operation
- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits and a `level` counter.
  - `full = (level == 2^DEPTH_LOG2)`, `empty = (level == 0)`.
  - Pointers wrap modulo depth.
  - `in_ready = !full && resetn`.
- When push and pop occur in the same cycle, `level` is unchanged and both pointers advance.
- A full FIFO does not accept a push even if a pop happens in the same cycle.
- An empty FIFO has no fall-through: a byte pushed this cycle is poppable from the next cycle onward.
- Drain FSM states:
  - IDLE: `reg_dat_we = 0`. If `!empty`: pop the head, load `reg_dat_di`, set `reg_dat_we = 1`, go to SEND.
  - SEND: hold `reg_dat_we` and `reg_dat_di` stable until accept (`!reg_dat_wait`). On accept:
    - if `!empty`, pop the next byte, load it, keep `reg_dat_we = 1`, stay in SEND;
    - otherwise clear `reg_dat_we` and go to IDLE.
  - CRPEND (only with CRLF_EN): see Configuration.
- `reg_dat_di[31:8]` is always 0.
- `flush` has priority over push and pop. In the cycle after `flush`:
  - `level = 0`, pointers are 0, `overflow = 0`;
  - `reg_dat_we = 0`, state is IDLE, and any pending CR is discarded.
- A flush on the same edge as an accept still counts the byte as sent.
- Reset (`resetn = 0` at a rising edge) produces the same state as flush. Output reset values: `reg_dat_we = 0`, `reg_dat_di = 0`, `level = 0`, `overflow = 0`, `in_ready = 0` while held in reset.
- Reset in the middle of a transmission drops the byte that has not been accepted; simpleuart will not see it, because the write strobe goes low.

## Timing
- Push-to-strobe latency from empty/IDLE:
  - push sampled at edge N;
  - `level` is 1 after edge N;
  - `reg_dat_we = 1` with the byte after edge N+1.
- Back-to-back bytes: the next byte is presented on the edge that completes the accept, so `reg_dat_we` stays high with no gap. simpleuart's own `reg_dat_wait` then throttles the transfer to one byte per frame (10 bit periods).
- `level` decrements on the pop edge, not on the accept edge. The byte being held in SEND is no longer counted.
- `in_ready` is combinational from `level` and `resetn`.
- `overflow` sets on the edge after the offending cycle.

## Configuration
- Macro `UART_TX_QUEUE_CRLF_EN`.
- Defined:
  - When the popped byte is 8'h0A, the FSM first presents 8'h0D and goes to SEND with a CR-pending flag.
  - When the CR is accepted, the FSM presents 8'h0A without popping, then continues normally.
  - Each LF costs one extra frame. `level` counts only queued bytes.
  - Flush or reset clears the CR-pending flag.
- Undefined: bytes are transmitted verbatim; no CRPEND logic is synthesised.

## Test plan
- Reset and idle: hold `resetn = 0` for 3 cycles with `in_valid = 1` -> `reg_dat_we = 0`, `reg_dat_di = 0`, `level = 0`, `in_ready = 0`, no push. After release -> `in_ready = 1`.
- Single byte: push 8'h41 at edge N with `reg_dat_wait = 0` -> `reg_dat_we = 1` and `reg_dat_di = 32'h41` after edge N+1; accepted at edge N+2; `reg_dat_we = 0` after it.
- Back-pressure and ordering: push "HELLO", and have the simpleuart model assert `reg_dat_wait` for 20 cycles after each accept -> accepted sequence 48 45 4C 4C 4F, `reg_dat_di` stable while wait is high, no duplicates.
- Full, wrap and overflow (DEPTH_LOG2 = 2), with `reg_dat_wait` held high:
  - push 6 bytes 0x30..0x35 -> the FSM pops 0x30 into SEND, so 0x31–0x34 fill the FIFO (`level = 4`), `in_ready = 0`, 0x35 is dropped and `overflow = 1`;
  - release wait -> output 0x30..0x34; pointers wrap correctly on a subsequent 4-byte burst.
- Flush mid-send: 3 bytes queued, first byte in SEND with wait high, pulse `flush` -> next cycle `reg_dat_we = 0`, `level = 0`, `overflow = 0`; a later push of 8'h5A transmits only 5A.
- CRLF (`UART_TX_QUEUE_CRLF_EN` defined): push 41 0A 42 -> accepted sequence 41 0D 0A 42. With the macro undefined -> 41 0A 42.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: transmit byte queue feeding the simpleuart data register.
// Producers push bytes through a valid/ready port. Bytes are buffered in a
// circular FIFO and then written one at a time into simpleuart through
// reg_dat_we/reg_dat_di, with reg_dat_wait acting as back-pressure.
// Optional feature macro: UART_TX_QUEUE_CRLF_EN. When it is defined, every
// LF is sent as CR followed by LF. When it is undefined, bytes are sent
// exactly as they were queued.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  reg_dat_we,
    output logic [31:0]           reg_dat_di,
    input  logic                  reg_dat_wait,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef UART_TX_QUEUE_CRLF_EN
        ST_CRPEND = 2'd2,
`endif
        ST_SEND   = 2'd1
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q;
    state_t                state_q;
    logic                  we_q;
    logic [7:0]            di_q;

    logic                  full, empty, push, pop, accept;
    logic [7:0]            head;
    logic [7:0]            load_di;
    state_t                load_state;

    // Handshakes:
    //  - The producer side transfers a byte on every cycle where in_valid
    //    and in_ready are both high, unless flush is high in that cycle.
    //  - The simpleuart side accepts a byte on every cycle where reg_dat_we
    //    is high and reg_dat_wait is low.
    //  - While the write strobe is waiting for acceptance, reg_dat_di is
    //    held stable.
    assign full     = (level_q == LEVEL_FULL);
    assign empty    = (level_q == '0);
    assign in_ready = !full && resetn;
    assign push     = in_valid && in_ready && !flush;
    assign accept   = we_q && !reg_dat_wait;
    assign head     = mem_q[rd_ptr_q];

    // Pop decision, FIFO next-state, and the byte/state to load on a pop.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE: pop = !empty;
            ST_SEND: pop = accept && !empty;
            default: pop = 1'b0;
        endcase
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        level_d    = level_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        load_di    = head;
        load_state = ST_SEND;
`ifdef UART_TX_QUEUE_CRLF_EN
        if (head == 8'h0A) begin
            load_di    = 8'h0D;
            load_state = ST_CRPEND;
        end
`endif
    end

    // Byte storage. Nothing is read here until the level says it is valid,
    // so this storage has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO bookkeeping and the drain FSM. Flush or reset overrides everything.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            di_q       <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (in_valid && full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        we_q    <= 1'b1;
                        di_q    <= load_di;
                        state_q <= load_state;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (pop) begin
                            di_q    <= load_di;
                            state_q <= load_state;
                        end else begin
                            we_q    <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
`ifdef UART_TX_QUEUE_CRLF_EN
                ST_CRPEND: begin
                    // The CR was accepted, so send the LF it stood in for.
                    // The LF was already popped, so nothing is popped here.
                    if (accept) begin
                        di_q    <= 8'h0A;
                        state_q <= ST_SEND;
                    end
                end
`endif
                default: begin
                    we_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_dat_we = we_q;
    assign reg_dat_di = {24'h0, di_q};
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue with DEPTH_LOG2 = 2. The reference model is a
// queue of the bytes simpleuart should see. Bytes are added when a push
// handshake happens, with an LF expanded to CR LF when the CRLF feature is
// enabled. The queue is cleared on flush or reset. Each accepted byte is
// checked against the front of the queue.
module tb_uart_tx_queue;
    localparam int DL2 = 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready;
    logic           flush = 1'b0;
    logic           reg_dat_we;
    logic [31:0]    reg_dat_di;
    logic           reg_dat_wait = 1'b0;
    logic [DL2:0]   level;
    logic           overflow;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] acc_log[$];
    int         acc_count = 0;

    // Controls for the simpleuart model.
    logic hold_wait = 1'b0;
    logic busy_mode = 1'b0;
    logic rand_mode = 1'b0;
    int   busy = 0;
    logic acc_seen = 1'b0;

    logic        prev_we = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_di = 32'h0;

    uart_tx_queue #(.DEPTH_LOG2(DL2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .flush        (flush),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_wait (reg_dat_wait),
        .level        (level),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // simpleuart model: the wait signal can be held high, stay busy for 20
    // cycles after each accept, or toggle randomly.
    always @(posedge clk) begin
        #1;
        if (acc_seen && busy_mode) busy = 20;
        else if (busy > 0) busy = busy - 1;
        reg_dat_wait = hold_wait || (busy > 0) || (rand_mode && ($urandom_range(0, 2) == 0));
    end

    // Monitor and scoreboard. Values are sampled on the falling edge, so they
    // are what the next rising edge will see.
    always @(negedge clk) begin
        acc_seen = reg_dat_we && !reg_dat_wait;
        if (acc_seen) begin
            check("di_upper_zero", {8'h0, reg_dat_di[31:8]}, 32'h0);
            check("model_has_byte", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) check("tx_byte", {24'h0, reg_dat_di[7:0]}, {24'h0, exp_q.pop_front()});
            acc_log.push_back(reg_dat_di[7:0]);
            acc_count++;
        end
        if (prev_we && prev_wait && reg_dat_we) check("di_stable", reg_dat_di, prev_di);
        if (!resetn || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
`ifdef UART_TX_QUEUE_CRLF_EN
            if (in_data == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(in_data);
        end
        prev_we   = reg_dat_we;
        prev_wait = reg_dat_wait;
        prev_di   = reg_dat_di;
    end

    // Push one byte, waiting for in_ready. Called at rising edge + 1.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                check("push_timeout", 32'h1, 32'h0);
                break;
            end
            @(posedge clk);
            #1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Wait until the model queue is drained and the strobe has dropped.
    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || reg_dat_we) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'h1, 32'h0);
        tick();
    endtask

    initial begin
        int base;
        logic [7:0] hello[5];
        logic [7:0] crlf_exp[$];

        // Reset held for 3 cycles with in_valid high.
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_we", {31'h0, reg_dat_we}, 32'h0);
            check("rst_di", reg_dat_di, 32'h0);
            check("rst_level", {29'h0, level}, 32'h0);
            check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        end
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_state_idle", {30'h0, dbg_state}, 32'h0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        check("post_rst_level", {29'h0, level}, 32'h0);

        // Single byte, observed cycle by cycle.
        in_valid = 1'b1;
        in_data  = 8'h41;
        tick();                     // edge N
        in_valid = 1'b0;
        check("single_level_n", {29'h0, level}, 32'h1);
        check("single_we_n", {31'h0, reg_dat_we}, 32'h0);
        tick();                     // edge N+1
        check("single_we_n1", {31'h0, reg_dat_we}, 32'h1);
        check("single_di_n1", reg_dat_di, 32'h41);
        check("single_level_n1", {29'h0, level}, 32'h0);
        tick();                     // edge N+2, accepted
        check("single_we_n2", {31'h0, reg_dat_we}, 32'h0);
        check("single_count", 32'(acc_count), 32'h1);

        // HELLO with a 20-cycle busy period after each accept.
        busy_mode = 1'b1;
        base = acc_count;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int i = 0; i < 5; i++) push_byte(hello[i]);
        wait_done();
        busy_mode = 1'b0;
        check("hello_count", 32'(acc_count - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < acc_log.size()) check("hello_order", {24'h0, acc_log[base + i]}, {24'h0, hello[i]});

        // Full FIFO and overflow with wait held high.
        hold_wait = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("full_level", {29'h0, level}, 32'd4);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        check("full_overflow", {31'h0, overflow}, 32'h1);
        check("full_we", {31'h0, reg_dat_we}, 32'h1);
        check("full_di_head", reg_dat_di, 32'h30);
        base = acc_count;
        hold_wait = 1'b0;
        wait_done();
        check("full_drain_count", 32'(acc_count - base), 32'd5);
        check("overflow_sticky", {31'h0, overflow}, 32'h1);

        // Burst that wraps the pointers.
        hold_wait = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_level", {29'h0, level}, 32'd4);
        base = acc_count;
        hold_wait = 1'b0;
        wait_done();
        check("wrap_count", 32'(acc_count - base), 32'd5);

        // Flush while a byte is being sent.
        hold_wait = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_flush_we", {31'h0, reg_dat_we}, 32'h1);
        check("pre_flush_level", {29'h0, level}, 32'd2);
        check("pre_flush_overflow", {31'h0, overflow}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_we", {31'h0, reg_dat_we}, 32'h0);
        check("flush_level", {29'h0, level}, 32'h0);
        check("flush_overflow", {31'h0, overflow}, 32'h0);
        check("flush_in_ready", {31'h0, in_ready}, 32'h1);
        hold_wait = 1'b0;
        base = acc_count;
        push_byte(8'h5A);
        wait_done();
        check("flush_after_count", 32'(acc_count - base), 32'd1);

        // Reset in the middle of a send drops the pending byte.
        hold_wait = 1'b1;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_we_before", {31'h0, reg_dat_we}, 32'h1);
        base = acc_count;
        resetn = 1'b0;
        tick();
        check("midrst_we", {31'h0, reg_dat_we}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        resetn = 1'b1;
        hold_wait = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_count", 32'(acc_count - base), 32'd0);

        // LF handling.
`ifdef UART_TX_QUEUE_CRLF_EN
        crlf_exp = '{8'h41, 8'h0D, 8'h0A, 8'h42};
`else
        crlf_exp = '{8'h41, 8'h0A, 8'h42};
`endif
        base = acc_count;
        push_byte(8'h41);
        push_byte(8'h0A);
        push_byte(8'h42);
        wait_done();
        check("crlf_count", 32'(acc_count - base), 32'(crlf_exp.size()));
        for (int i = 0; i < crlf_exp.size(); i++)
            if (base + i < acc_log.size()) check("crlf_seq", {24'h0, acc_log[base + i]}, {24'h0, crlf_exp[i]});

        // Random traffic, random back-pressure and occasional flushes.
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
            flush    = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rand_mode = 1'b0;
        tick();
        wait_done();
        check("final_model_empty", 32'(exp_q.size()), 32'h0);
        check("final_level", {29'h0, level}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time limit.
    initial begin
        #2000000;
        check("global_timeout", 32'h1, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
